// File: rtl/mul_pkg.sv
// Shared types and defaults for the shift-add multiply sequencer.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  localparam int MUL_DEFAULT_N = 16;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: multiplicand, multiplier and accumulator registers,
// advanced one multiplier bit per step strobe.
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int N = MUL_DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [N-1:0]   i_opa,
  input  logic [N-1:0]   i_opb,
  output logic [2*N-1:0] o_acc,
  output logic [2*N-1:0] o_acc_next,
  output logic           o_mplier_zero
);

  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] w_addend;

  assign w_addend      = r_mplier[0] ? r_mcand : '0;
  // The product fits in 2N bits, so this add can never carry out.
  assign o_acc_next    = r_acc + w_addend;
  assign o_acc         = r_acc;
  assign o_mplier_zero = (r_mplier == '0);

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{N{1'b0}}, i_opa};
      r_mplier <= i_opb;
      r_acc    <= '0;
    end else if (i_step) begin
      r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
      r_mplier <= r_mplier >> 1;
      r_acc    <= o_acc_next;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiply sequencer with valid/ready on both sides.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int N = MUL_DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   opA,
  input  logic [N-1:0]   opB,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic           ovf,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  mul_state_e     r_state;
  logic [CW-1:0]  r_cnt;
  logic           w_load;
  logic           w_run;
  logic           w_skip;
  logic           w_step;
  logic           w_last;
  logic [2*N-1:0] w_acc;
  logic [2*N-1:0] w_acc_next;
  logic           w_mplier_zero;

  assign w_load = (r_state == MUL_IDLE) && in_valid;
  assign w_run  = (r_state == MUL_RUN);
  assign w_skip = w_run && EARLY_EXIT && w_mplier_zero;
  assign w_step = w_run && !w_skip;
  assign w_last = (r_cnt == CW'(N - 1));

  mul_shift_add_dp #(.N(N)) u_dp (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_opa         (opA),
    .i_opb         (opB),
    .o_acc         (w_acc),
    .o_acc_next    (w_acc_next),
    .o_mplier_zero (w_mplier_zero)
  );

  // result/ovf are captured on the edge entering DONE so they stay frozen
  // while the datapath is reloaded for the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MUL_IDLE;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (in_valid) begin
            r_state  <= MUL_RUN;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL_RUN: begin
          if (w_skip) begin
            r_state   <= MUL_DONE;
            out_valid <= 1'b1;
            result    <= w_acc;
            ovf       <= |w_acc[2*N-1:N];
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state   <= MUL_DONE;
              out_valid <= 1'b1;
              result    <= w_acc_next;
              ovf       <= |w_acc_next[2*N-1:N];
            end
          end
        end
        MUL_DONE: begin
          if (out_ready) begin
            r_state   <= MUL_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= MUL_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: the driver queues expected products and
// latencies on accept, a monitor checks them whenever out_valid is high.
module tb_mul_sequencer;

  localparam int N = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   opA;
  logic [N-1:0]   opB;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] result;
  logic           ovf;
  logic           busy;

  typedef struct {
    logic [2*N-1:0] res;
    logic           ovf;
    int             lat;
    int             e0;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_valid = 1'b0;
  bit   rnd_on = 1'b0;

  mul_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h = -1;
    for (int i = 0; i < N; i++) if (b[i]) h = i;
    if (h < 0) return 1;
    return (h + 2 > N) ? N : h + 2;
`else
    return N;
`endif
  endfunction

  // Present operands, wait for the accept edge, then queue the expectation.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, output int e0);
    logic [2*N-1:0] p;
    int k;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    opA = a;
    opB = b;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) timeout("accept");
    @(posedge clk);
    #1;
    e0 = cyc;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    e.res = p;
    e.ovf = |p[2*N-1:N];
    e.lat = exp_lat(b);
    e.e0  = e0;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      timeout("drain");
      sb.delete();
    end
  endtask

  // Monitor: latency on the rising out_valid, product every cycle it is held.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          if (!prev_valid) check("latency", cyc - sb[0].e0, sb[0].lat);
          check("result", result, sb[0].res);
          check("ovf", ovf, sb[0].ovf);
          check("in_ready_done", in_ready, 1'b0);
          check("busy_done", busy, 1'b1);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int e_a, e_b, k;
    logic [N-1:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opA = '0;
    opB = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_result", result, '0);
    check("idle_ovf", ovf, 1'b0);

    // Basic product and minimum issue interval.
    out_ready = 1'b1;
    issue(16'h0003, 16'h0005, e_a);
    issue(16'h00FF, 16'h0101, e_b);
    check("issue_interval", e_b - e_a, exp_lat(16'h0005) + 2);
    drain();

    // Back-pressure: result and ovf held while out_ready is low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(16'hFFFF, 16'hFFFF, e_a);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) timeout("wait_valid");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("post_done_in_ready", in_ready, 1'b1);
    check("post_done_busy", busy, 1'b0);
    check("post_done_result", result, 32'hFFFE_0001);
    check("post_done_ovf", ovf, 1'b1);

    // in_valid pulsed during RUN must be ignored.
    issue(16'h00FF, 16'h0101, e_a);
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    opA = 16'h1234;
    opB = 16'h0003;
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Reset mid-run aborts the operation.
    issue(16'h00FF, 16'h0101, e_a);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, '0);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);
    issue(16'h00FF, 16'h0101, e_a);
    drain();

    // Boundary operands, including the early-exit latency corners.
    issue(16'h0000, 16'h1234, e_a);
    issue(16'h1234, 16'h0000, e_a);
    issue(16'h0007, 16'h0001, e_a);
    issue(16'h0001, 16'h8000, e_a);
    issue(16'h8001, 16'h4000, e_a);
    issue(16'h0100, 16'h0100, e_a);
    drain();

    // Random operands with random output back-pressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i % 17 == 0) rb = N'(rb >> (i % N));
      issue(ra, rb, e_a);
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
